// File: rtl/vram_arbiter_pkg.sv
// vram_arbiter_pkg: shared SRAM constants, default timings and access state encoding
package vram_arbiter_pkg;
  localparam int SRAM_AW = 19;
  localparam int SRAM_DW = 8;
  localparam int DEF_RD_CYCLES = 2;
  localparam int DEF_WR_CYCLES = 2;
  localparam int DEF_MAX_STREAK = 8;
  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    RD       = 3'd1,
    RD_DONE  = 3'd2,
    WR_SETUP = 3'd3,
    WR_PULSE = 3'd4,
    WR_HOLD  = 3'd5
  } state_e;
  function automatic logic is_wr(input state_e s);
    return s inside {WR_SETUP, WR_PULSE, WR_HOLD};
  endfunction
endpackage

// File: rtl/vram_cycle.sv
// vram_cycle: SRAM access sequencer; one read or write per start with fixed strobe timing
module vram_cycle
  import vram_arbiter_pkg::*;
#(
  parameter int AWIDTH    = SRAM_AW,
  parameter int DWIDTH    = SRAM_DW,
  parameter int RD_CYCLES = DEF_RD_CYCLES,
  parameter int WR_CYCLES = DEF_WR_CYCLES
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              start_i,
  input  logic              is_write_i,
  input  logic [AWIDTH-1:0] addr_i,
  input  logic [DWIDTH-1:0] data_i,
  input  logic [DWIDTH-1:0] rd_data_i,
  output logic [2:0]        state_o,
  output logic [AWIDTH-1:0] mem_addr_o,
  output logic [DWIDTH-1:0] mem_data_o,
  output logic              mem_drive_o,
  output logic              mem_we_o,
  output logic              mem_oe_o,
  output logic [DWIDTH-1:0] rd_data_o,
  output logic              rd_done_o,
  output logic              wr_done_o
);
  localparam int MAXC = RD_CYCLES > WR_CYCLES ? RD_CYCLES : WR_CYCLES;
  localparam int CW = $clog2(MAXC + 1);
  state_e            state_q;
  logic [CW-1:0]     cnt_q;
  logic [AWIDTH-1:0] addr_q;
  logic [DWIDTH-1:0] wdata_q, rdata_q;
  logic              drive_q, we_q, oe_q, rd_done_q, wr_done_q;
  assign state_o     = state_q;
  assign mem_addr_o  = addr_q;
  assign mem_data_o  = wdata_q;
  assign mem_drive_o = drive_q;
  assign mem_we_o    = we_q;
  assign mem_oe_o    = oe_q;
  assign rd_data_o   = rdata_q;
  assign rd_done_o   = rd_done_q;
  assign wr_done_o   = wr_done_q;
  // Access FSM: address latched at start and held until the access returns to IDLE
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      addr_q    <= '0;
      wdata_q   <= '0;
      rdata_q   <= '0;
      drive_q   <= 1'b0;
      we_q      <= 1'b1;
      oe_q      <= 1'b1;
      rd_done_q <= 1'b0;
      wr_done_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: if (start_i) begin
          addr_q <= addr_i;
          cnt_q  <= CW'(1);
          if (is_write_i) begin
            wdata_q <= data_i;
            drive_q <= 1'b1;
            state_q <= WR_SETUP;
          end else begin
            oe_q    <= 1'b0;
            state_q <= RD;
          end
        end
        RD: if (cnt_q == CW'(RD_CYCLES)) begin
          rdata_q   <= rd_data_i;
          oe_q      <= 1'b1;
          rd_done_q <= 1'b1;
          state_q   <= RD_DONE;
        end else cnt_q <= cnt_q + 1'b1;
        RD_DONE: begin
          rd_done_q <= 1'b0;
          state_q   <= IDLE;
        end
        WR_SETUP: begin
          we_q    <= 1'b0;
          cnt_q   <= CW'(1);
          state_q <= WR_PULSE;
        end
        WR_PULSE: if (cnt_q == CW'(WR_CYCLES)) begin
          we_q      <= 1'b1;
          wr_done_q <= 1'b1;
          state_q   <= WR_HOLD;
        end else cnt_q <= cnt_q + 1'b1;
        WR_HOLD: begin
          drive_q   <= 1'b0;
          wr_done_q <= 1'b0;
          state_q   <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule

// File: rtl/vram_arbiter.sv
// vram_arbiter: display-priority SRAM arbiter with host streak guarantee; VRAM_ARB_STATS_EN adds HostStallCnt
module vram_arbiter
  import vram_arbiter_pkg::*;
#(
  parameter int AWIDTH     = SRAM_AW,
  parameter int DWIDTH     = SRAM_DW,
  parameter int RD_CYCLES  = DEF_RD_CYCLES,
  parameter int WR_CYCLES  = DEF_WR_CYCLES,
  parameter int MAX_STREAK = DEF_MAX_STREAK
) (
  input  logic              MemClk,
  input  logic              RstN,
  input  logic              DispReq,
  input  logic [AWIDTH-1:0] DispAddr,
  output logic [DWIDTH-1:0] DispData,
  output logic              DispRdy,
  input  logic              HostReq,
  input  logic [AWIDTH-1:0] HostAddr,
  input  logic [DWIDTH-1:0] HostData,
  output logic              HostAck,
  output logic [AWIDTH-1:0] MemAddr,
  output logic [DWIDTH-1:0] MemDataOut,
  output logic              MemDataDrive,
  input  logic [DWIDTH-1:0] MemDataIn,
  output logic              MemWE,
  output logic              MemOE
`ifdef VRAM_ARB_STATS_EN
  ,output logic [15:0]      HostStallCnt
`endif
);
  localparam int SW = $clog2(MAX_STREAK + 1);
  logic [2:0]    st;
  logic [SW-1:0] streak_q, streak_d;
  logic          idle, host_sel, disp_sel, start;
  assign idle     = st == IDLE;
  assign host_sel = HostReq && (!DispReq || streak_q == SW'(MAX_STREAK));
  assign disp_sel = DispReq && !host_sel;
  assign start    = idle && (host_sel || disp_sel);
  // Streak only moves on IDLE edges: cleared when host is served or absent, else counts display grants
  always_comb begin
    streak_d = !idle ? streak_q
             : (!HostReq || host_sel) ? '0
             : (streak_q != SW'(MAX_STREAK)) ? streak_q + 1'b1 : streak_q;
  end
  // Streak register
  always_ff @(posedge MemClk or negedge RstN) begin
    if (!RstN) streak_q <= '0;
    else streak_q <= streak_d;
  end
  vram_cycle #(
    .AWIDTH(AWIDTH), .DWIDTH(DWIDTH), .RD_CYCLES(RD_CYCLES), .WR_CYCLES(WR_CYCLES)
  ) u_cycle (
    .clk_i      (MemClk),
    .rst_ni     (RstN),
    .start_i    (start),
    .is_write_i (host_sel),
    .addr_i     (host_sel ? HostAddr : DispAddr),
    .data_i     (HostData),
    .rd_data_i  (MemDataIn),
    .state_o    (st),
    .mem_addr_o (MemAddr),
    .mem_data_o (MemDataOut),
    .mem_drive_o(MemDataDrive),
    .mem_we_o   (MemWE),
    .mem_oe_o   (MemOE),
    .rd_data_o  (DispData),
    .rd_done_o  (DispRdy),
    .wr_done_o  (HostAck)
  );
`ifdef VRAM_ARB_STATS_EN
  logic [15:0] stall_q;
  assign HostStallCnt = stall_q;
  // Saturating count of cycles the host waits outside its own write
  always_ff @(posedge MemClk or negedge RstN) begin
    if (!RstN) stall_q <= '0;
    else if (HostReq && !is_wr(state_e'(st)) && stall_q != 16'hFFFF) stall_q <= stall_q + 1'b1;
  end
`endif
endmodule

// File: tb/tb_vram_arbiter.sv
// tb_vram_arbiter: directed + randomized bench for vram_arbiter with SRAM and arbitration models
module tb_vram_arbiter;
  localparam int RDC = 2;
  localparam int WRC = 2;
  localparam int MS  = 8;
  logic        MemClk = 1'b0;
  logic        RstN = 1'b0;
  logic        DispReq = 1'b0, HostReq = 1'b0;
  logic [18:0] DispAddr = '0, HostAddr = '0;
  logic [7:0]  HostData = '0;
  logic [7:0]  DispData, MemDataOut, MemDataIn;
  logic        DispRdy, HostAck, MemDataDrive, MemWE, MemOE;
  logic [18:0] MemAddr;
  logic [7:0]  sram [0:524287];
  logic [7:0]  ref_mem [0:15];
  int          total = 0, passed = 0, fails = 0;
`ifdef VRAM_ARB_STATS_EN
  logic [15:0] HostStallCnt, stall_m;
`endif

  vram_arbiter dut (
    .MemClk(MemClk), .RstN(RstN),
    .DispReq(DispReq), .DispAddr(DispAddr), .DispData(DispData), .DispRdy(DispRdy),
    .HostReq(HostReq), .HostAddr(HostAddr), .HostData(HostData), .HostAck(HostAck),
    .MemAddr(MemAddr), .MemDataOut(MemDataOut), .MemDataDrive(MemDataDrive),
    .MemDataIn(MemDataIn), .MemWE(MemWE), .MemOE(MemOE)
`ifdef VRAM_ARB_STATS_EN
    , .HostStallCnt(HostStallCnt)
`endif
  );

  always #5 MemClk = ~MemClk;

  assign MemDataIn = MemOE ? 8'h00 : sram[MemAddr];
  always @(posedge MemWE) if (MemDataDrive === 1'b1 && RstN) sram[MemAddr] = MemDataOut;

`ifdef VRAM_ARB_STATS_EN
  always @(posedge MemClk or negedge RstN)
    if (!RstN) stall_m <= '0;
    else if (HostReq && !MemDataDrive && stall_m != 16'hFFFF) stall_m <= stall_m + 1'b1;
`endif

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic do_read(input logic [18:0] a, input logic [7:0] e);
    int n, oe_lo, we_lo;
    n = 1; oe_lo = 0; we_lo = 0;
    @(negedge MemClk); DispAddr = a; DispReq = 1'b1;
    @(posedge MemClk); #1;
    while (!DispRdy && n < 50) begin
      if (!MemOE) oe_lo++;
      if (!MemWE) we_lo++;
      chk("rd_addr_stable", MemAddr, a);
      chk("rd_no_drive", MemDataDrive, 0);
      @(posedge MemClk); #1; n++;
    end
    DispReq = 1'b0;
    chk("rd_latency", n, RDC + 1);
    chk("rd_oe_cycles", oe_lo, RDC);
    chk("rd_we_idle", we_lo, 0);
    chk("rd_data", DispData, e);
    chk("rd_oe_released", MemOE, 1);
    @(posedge MemClk); #1;
    chk("rd_rdy_pulse", DispRdy, 0);
    chk("rd_data_hold", DispData, e);
  endtask

  task automatic do_write(input logic [18:0] a, input logic [7:0] d);
    int n, drv, we_lo;
    n = 1; drv = 0; we_lo = 0;
    @(negedge MemClk); HostAddr = a; HostData = d; HostReq = 1'b1;
    @(posedge MemClk); #1;
    while (!HostAck && n < 50) begin
      if (MemDataDrive) drv++;
      if (!MemWE) we_lo++;
      chk("wr_addr_stable", MemAddr, a);
      chk("wr_oe_idle", MemOE, 1);
      @(posedge MemClk); #1; n++;
    end
    HostReq = 1'b0;
    if (MemDataDrive) drv++;
    chk("wr_ack_edges", n, WRC + 2);
    chk("wr_we_cycles", we_lo, WRC);
    chk("wr_we_released", MemWE, 1);
    chk("wr_data_out", MemDataOut, d);
    @(posedge MemClk); #1;
    if (MemDataDrive) drv++;
    chk("wr_drive_cycles", drv, WRC + 2);
    chk("wr_ack_pulse", HostAck, 0);
    chk("wr_sram", sram[a], d);
  endtask

  initial begin
    int viol, a1, a2, s, ge, got, idx, c;
    int g[$];
    logic po, pd;
    logic [7:0] d;
    logic [18:0] a;
    repeat (3) @(posedge MemClk);
    #1;
    chk("rst_we", MemWE, 1);
    chk("rst_oe", MemOE, 1);
    chk("rst_drive", MemDataDrive, 0);
    chk("rst_addr", MemAddr, 0);
    chk("rst_dout", MemDataOut, 0);
    chk("rst_ddata", DispData, 0);
    chk("rst_rdy", DispRdy, 0);
    chk("rst_ack", HostAck, 0);
    for (int i = 0; i < 16; i++) begin
      ref_mem[i] = 8'($urandom);
      sram[19'h40000 + i] = ref_mem[i];
    end
    sram[19'h00010] = 8'h3C;
    @(negedge MemClk); RstN = 1'b1;
    repeat (2) @(posedge MemClk);
    do_read(19'h00010, 8'h3C);
    do_write(19'h7FFFF, 8'h0C);
    for (int k = 0; k < 24; k++) begin
      idx = $urandom_range(0, 15);
      a = 19'h40000 + 19'(idx);
      if ($urandom_range(0, 1) == 1) begin
        d = 8'($urandom);
        do_write(a, d);
        ref_mem[idx] = d;
      end else do_read(a, ref_mem[idx]);
    end
    viol = 0; a1 = -1; a2 = -1; po = 1'b1; pd = 1'b0;
    @(negedge MemClk);
    DispAddr = 19'h40003; HostAddr = 19'h40009; HostData = 8'h96;
    DispReq = 1'b1; HostReq = 1'b1;
    c = 0;
    while (c < 600 && g.size() < 19) begin
      @(posedge MemClk); #1;
      if (!MemOE && po) g.push_back(0);
      if (MemDataDrive && !pd) g.push_back(1);
      if (HostAck) begin
        if (a1 < 0) a1 = c;
        else if (a2 < 0) a2 = c;
      end
      if ((!MemOE && !MemWE) || (MemDataDrive && !MemOE)) viol++;
      if (DispRdy && DispData !== ref_mem[3]) viol++;
      po = MemOE; pd = MemDataDrive; c++;
    end
    DispReq = 1'b0; HostReq = 1'b0;
    ref_mem[9] = 8'h96;
    chk("cont_grant_count", g.size(), 19);
    s = 0;
    for (int k = 0; k < 19; k++) begin
      ge = (s == MS) ? 1 : 0;
      s = ge == 1 ? 0 : (s < MS ? s + 1 : s);
      got = k < g.size() ? g[k] : 2;
      chk($sformatf("cont_grant%0d", k), got, ge);
    end
    chk("cont_ack_period", a2 - a1, MS * (RDC + 2) + WRC + 3);
    chk("cont_invariants", viol, 0);
    repeat (8) @(posedge MemClk);
    chk("cont_wr_sram", sram[19'h40009], 8'h96);
    @(negedge MemClk); HostAddr = 19'h40020; HostData = 8'hA5; HostReq = 1'b1;
    c = 0;
    while (MemWE && c < 20) begin
      @(posedge MemClk); #1; c++;
    end
    chk("rst_mid_reached_pulse", MemWE, 0);
    #2;
    RstN = 1'b0; HostReq = 1'b0;
    #1;
    chk("rst_mid_we", MemWE, 1);
    chk("rst_mid_drive", MemDataDrive, 0);
    chk("rst_mid_ack", HostAck, 0);
    chk("rst_mid_oe", MemOE, 1);
    chk("rst_mid_addr", MemAddr, 0);
    @(negedge MemClk); RstN = 1'b1;
    do_read(19'h40001, ref_mem[1]);
    do_write(19'h40007, 8'h5A);
    ref_mem[7] = 8'h5A;
    do_read(19'h40007, ref_mem[7]);
`ifdef VRAM_ARB_STATS_EN
    #1;
    chk("stall_cnt", HostStallCnt, stall_m);
`endif
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
